// File: rtl/linebuffer_window.sv
// ----------------------------------------------------------------------------
// linebuffer_window
//
// Line buffer and ROWS x COLS stencil-window generator for a row-major raster
// stream of IMG_W x IMG_H pixels. ROWS-1 line memories keep the previous rows.
// A register array holds the most recent COLS column vectors. out_valid marks
// windows whose pixels all come from the current frame and from one row span,
// with no wrap across the left/right image edge.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset (wins over in_valid)
//   in_data    in   WIDTH-bit input pixel
//   in_valid   in   pixel accepted this cycle (block is always ready)
//   out_data   out  ROWS*COLS*WIDTH window, element (r,c) at
//                   [(r*COLS+c)*WIDTH +: WIDTH], r=0 oldest row, c=0 oldest col
//   out_valid  out  out_data holds a complete in-frame window
//   out_last   out  window whose bottom-right pixel is (IMG_H-1, IMG_W-1)
// ----------------------------------------------------------------------------
module linebuffer_window #(
   parameter int WIDTH = 16,
   parameter int IMG_W = 10,
   parameter int IMG_H = 10,
   parameter int ROWS  = 3,
   parameter int COLS  = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_valid,
   output logic [ROWS*COLS*WIDTH-1:0]  out_data,
   output logic                        out_valid,
   output logic                        out_last
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_FIRST_WIN = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(ROWS - 1);

   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [WIDTH-1:0] r_lm  [ROWS-1][IMG_W];
   logic [WIDTH-1:0] r_win [ROWS][COLS];
   logic             r_valid;
   logic             r_last;

   logic [WIDTH-1:0] w_col [ROWS];
   logic             w_accept;
   logic             w_col_ok;
   logic             w_row_ok;
   logic             w_win_ok;
   logic             w_col_wrap;

   // A pixel arriving in the reset cycle is dropped, so reset gates the write
   // enable for the line memories as well as the counters.
   assign w_accept   = in_valid & ~rst;
   assign w_col_wrap = (r_col == COL_LAST);
   assign w_row_ok   = (r_row >= ROW_FIRST_WIN);

   // With a single-column window every column position is a valid right edge.
   generate
      if (COLS > 1) begin : g_col_chk
         assign w_col_ok = (r_col >= COL_FIRST_WIN);
      end else begin : g_col_any
         assign w_col_ok = 1'b1;
      end
   endgenerate

   assign w_win_ok = w_row_ok & w_col_ok;

   // Column vector: newest row from the input, older rows from the memories.
   assign w_col[ROWS-1] = in_data;
   generate
      for (genvar k = 0; k < ROWS-1; k++) begin : g_col_vec
         assign w_col[ROWS-2-k] = r_lm[k][r_col];
      end
   endgenerate

   // NOTE: the line memories have no reset so they map onto plain RAM; stale
   // contents are never seen because out_valid comes only from the counters.
   // NOTE: non-blocking writes make every read in this cycle see the old
   // value, which gives the read-before-write cascade lm[k] <= lm[k-1].
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lm[0][r_col] <= in_data;
         for (int k = 1; k < ROWS-1; k++) begin
            r_lm[k][r_col] <= r_lm[k-1][r_col];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col   <= '0;
         r_row   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (w_accept) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS-1; c++) begin
               r_win[r][c] <= r_win[r][c+1];
            end
            r_win[r][COLS-1] <= w_col[r];
         end
         r_valid <= w_win_ok;
         r_last  <= w_win_ok && (r_row == ROW_LAST) && w_col_wrap;
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end else begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end

   generate
      for (genvar r = 0; r < ROWS; r++) begin : g_out_r
         for (genvar c = 0; c < COLS; c++) begin : g_out_c
            assign out_data[(r*COLS+c)*WIDTH +: WIDTH] = r_win[r][c];
         end
      end
   endgenerate

   assign out_valid = r_valid;
   assign out_last  = r_last;

endmodule

// File: tb/tb_linebuffer_window.sv
// ----------------------------------------------------------------------------
// tb_linebuffer_window
//
// Two instances: a 3x3 window over a 4x4 image (dut1) and a 2x1 window over a
// 10x3 image (dut2). Pixel value is base + 10*row + col. The expected window
// with bottom-right pixel (R,C) is built from image coordinates.
// ----------------------------------------------------------------------------
module tb_linebuffer_window;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst1, in_valid1, out_valid1, out_last1;
   logic [15:0]  in_data1;
   logic [143:0] out_data1;

   logic         rst2, in_valid2, out_valid2, out_last2;
   logic [15:0]  in_data2;
   logic [31:0]  out_data2;

   int n_pass  = 0;
   int n_total = 0;

   linebuffer_window #(.WIDTH(16), .IMG_W(4), .IMG_H(4), .ROWS(3), .COLS(3)) dut1 (
      .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1),
      .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1));

   linebuffer_window #(.WIDTH(16), .IMG_W(10), .IMG_H(3), .ROWS(2), .COLS(1)) dut2 (
      .clk(clk), .rst(rst2), .in_data(in_data2), .in_valid(in_valid2),
      .out_data(out_data2), .out_valid(out_valid2), .out_last(out_last2));

   function automatic logic [143:0] exp_win1(input int R, input int C, input int base);
      logic [143:0] w;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w[(r*3+c)*16 +: 16] = 16'(base + 10*(R-2+r) + (C-2+c));
         end
      end
      return w;
   endfunction

   function automatic logic [31:0] exp_win2(input int R, input int C);
      return {16'(10*R + C), 16'(10*(R-1) + C)};
   endfunction

   task automatic step1(input logic v, input logic [15:0] d, input logic r);
      @(negedge clk);
      in_valid1 = v;
      in_data1  = d;
      rst1      = r;
      @(posedge clk);
      #1;
   endtask

   task automatic step2(input logic v, input logic [15:0] d, input logic r);
      @(negedge clk);
      in_valid2 = v;
      in_data2  = d;
      rst2      = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst1 = 1'b1; in_valid1 = 1'b1; in_data1 = 16'h0055;
      rst2 = 1'b1; in_valid2 = 1'b1; in_data2 = 16'h0055;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (out_data1 !== '0) $display("FAIL reset_data1 got %h want 0", out_data1);
      else n_pass++;
      n_total++;
      if ({out_valid1, out_last1} !== 2'b00)
         $display("FAIL reset_flags1 got %b want 00", {out_valid1, out_last1});
      else n_pass++;
      n_total++;
      if (out_data2 !== '0 || {out_valid2, out_last2} !== 2'b00)
         $display("FAIL reset_dut2 got %h/%b want 0/00", out_data2, {out_valid2, out_last2});
      else n_pass++;
      @(negedge clk);
      rst1 = 1'b0; in_valid1 = 1'b0;
      rst2 = 1'b0; in_valid2 = 1'b0;
   endtask

   task automatic test_stream;
      int pulses = 0;
      logic expv;
      for (int R = 0; R < 4; R++) begin
         for (int C = 0; C < 4; C++) begin
            step1(1'b1, 16'(10*R + C), 1'b0);
            expv = (R >= 2) && (C >= 2);
            if (out_valid1) pulses++;
            n_total++;
            if (out_valid1 !== expv || out_last1 !== (expv && R == 3 && C == 3))
               $display("FAIL stream_flags (%0d,%0d) got v=%b l=%b want v=%b", R, C,
                        out_valid1, out_last1, expv);
            else n_pass++;
            if (expv) begin
               n_total++;
               if (out_data1 !== exp_win1(R, C, 0))
                  $display("FAIL stream_win (%0d,%0d) got %h want %h", R, C, out_data1,
                           exp_win1(R, C, 0));
               else n_pass++;
            end
         end
      end
      n_total++;
      if (pulses !== 4) $display("FAIL stream_pulses got %0d want 4", pulses);
      else n_pass++;
      step1(1'b0, 16'hBEEF, 1'b0);
      n_total++;
      if (out_valid1 !== 1'b0 || out_data1 !== exp_win1(3, 3, 0))
         $display("FAIL stream_idle got v=%b d=%h want v=0 d=%h", out_valid1, out_data1,
                  exp_win1(3, 3, 0));
      else n_pass++;
   endtask

   task automatic test_gaps;
      logic [15:0]  gap_pat;
      logic [143:0] expw;
      logic         known;
      logic         expv;
      int           pulses;
      gap_pat = 16'b1011_0100_1101_0110;
      known   = 1'b0;
      expw    = '0;
      pulses  = 0;
      for (int R = 0; R < 4; R++) begin
         for (int C = 0; C < 4; C++) begin
            if (gap_pat[R*4+C]) begin
               step1(1'b0, 16'hDEAD, 1'b0);
               n_total++;
               if (out_valid1 !== 1'b0 || out_last1 !== 1'b0)
                  $display("FAIL gap_flags (%0d,%0d) got v=%b l=%b want 0", R, C,
                           out_valid1, out_last1);
               else n_pass++;
               if (known) begin
                  n_total++;
                  if (out_data1 !== expw)
                     $display("FAIL gap_hold (%0d,%0d) got %h want %h", R, C, out_data1, expw);
                  else n_pass++;
               end
            end
            step1(1'b1, 16'(10*R + C), 1'b0);
            expv = (R >= 2) && (C >= 2);
            if (out_valid1) pulses++;
            n_total++;
            if (out_valid1 !== expv)
               $display("FAIL gap_valid (%0d,%0d) got %b want %b", R, C, out_valid1, expv);
            else n_pass++;
            if (expv) begin
               n_total++;
               if (out_data1 !== exp_win1(R, C, 0))
                  $display("FAIL gap_win (%0d,%0d) got %h want %h", R, C, out_data1,
                           exp_win1(R, C, 0));
               else n_pass++;
            end
            known = expv;
            expw  = exp_win1(R, C, 0);
         end
      end
      step1(1'b0, 16'hDEAD, 1'b0);
      n_total++;
      if (out_valid1 !== 1'b0 || out_data1 !== exp_win1(3, 3, 0))
         $display("FAIL gap_tail got v=%b d=%h want v=0 d=%h", out_valid1, out_data1,
                  exp_win1(3, 3, 0));
      else n_pass++;
      n_total++;
      if (pulses !== 4) $display("FAIL gap_pulses got %0d want 4", pulses);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int   pulses = 0;
      logic expv;
      for (int f = 0; f < 2; f++) begin
         for (int R = 0; R < 4; R++) begin
            for (int C = 0; C < 4; C++) begin
               step1(1'b1, 16'(100*f + 10*R + C), 1'b0);
               expv = (R >= 2) && (C >= 2);
               if (out_valid1) pulses++;
               n_total++;
               if (out_valid1 !== expv || out_last1 !== (expv && R == 3 && C == 3))
                  $display("FAIL b2b_flags f%0d (%0d,%0d) got v=%b l=%b want v=%b", f, R, C,
                           out_valid1, out_last1, expv);
               else n_pass++;
               if (expv) begin
                  n_total++;
                  if (out_data1 !== exp_win1(R, C, 100*f))
                     $display("FAIL b2b_win f%0d (%0d,%0d) got %h want %h", f, R, C,
                              out_data1, exp_win1(R, C, 100*f));
                  else n_pass++;
               end
            end
         end
      end
      n_total++;
      if (pulses !== 8) $display("FAIL b2b_pulses got %0d want 8", pulses);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int   n_acc     = 0;
      int   first_acc = 0;
      logic expv;
      for (int i = 0; i < 7; i++) begin
         step1(1'b1, 16'(50 + 10*(i/4) + (i%4)), 1'b0);
         n_total++;
         if (out_valid1 !== 1'b0)
            $display("FAIL pre_reset_valid acc%0d got %b want 0", i, out_valid1);
         else n_pass++;
      end
      step1(1'b1, 16'h0999, 1'b1);
      n_total++;
      if (out_data1 !== '0 || {out_valid1, out_last1} !== 2'b00)
         $display("FAIL midreset_out got %h/%b want 0/00", out_data1, {out_valid1, out_last1});
      else n_pass++;
      for (int R = 0; R < 4; R++) begin
         for (int C = 0; C < 4; C++) begin
            step1(1'b1, 16'(200 + 10*R + C), 1'b0);
            n_acc++;
            expv = (R >= 2) && (C >= 2);
            if (out_valid1 && first_acc == 0) first_acc = n_acc;
            n_total++;
            if (out_valid1 !== expv)
               $display("FAIL restart_valid (%0d,%0d) got %b want %b", R, C, out_valid1, expv);
            else n_pass++;
            if (expv) begin
               n_total++;
               if (out_data1 !== exp_win1(R, C, 200))
                  $display("FAIL restart_win (%0d,%0d) got %h want %h", R, C, out_data1,
                           exp_win1(R, C, 200));
               else n_pass++;
            end
         end
      end
      n_total++;
      if (first_acc !== 11) $display("FAIL restart_first got %0d want 11", first_acc);
      else n_pass++;
   endtask

   task automatic test_small;
      int   n_acc     = 0;
      int   first_acc = 0;
      int   pulses    = 0;
      logic expv;
      for (int R = 0; R < 3; R++) begin
         for (int C = 0; C < 10; C++) begin
            step2(1'b1, 16'(10*R + C), 1'b0);
            n_acc++;
            expv = (R >= 1);
            if (out_valid2) begin
               pulses++;
               if (first_acc == 0) first_acc = n_acc;
            end
            n_total++;
            if (out_valid2 !== expv || out_last2 !== (R == 2 && C == 9))
               $display("FAIL small_flags (%0d,%0d) got v=%b l=%b want v=%b", R, C,
                        out_valid2, out_last2, expv);
            else n_pass++;
            if (expv) begin
               n_total++;
               if (out_data2 !== exp_win2(R, C))
                  $display("FAIL small_win (%0d,%0d) got %h want %h", R, C, out_data2,
                           exp_win2(R, C));
               else n_pass++;
            end
         end
      end
      n_total++;
      if (first_acc !== 11) $display("FAIL small_first got %0d want 11", first_acc);
      else n_pass++;
      n_total++;
      if (pulses !== 20) $display("FAIL small_pulses got %0d want 20", pulses);
      else n_pass++;
      n_total++;
      if (out_data2 !== 32'h001D_0013)
         $display("FAIL small_last_win got %h want 001d0013", out_data2);
      else n_pass++;
   endtask

   initial begin
      rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0;
      rst2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0;
      test_reset;
      test_stream;
      test_gaps;
      test_back_to_back;
      test_reset_mid;
      test_small;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/linebuffer_window.md
# linebuffer_window

Parametrised line buffer and stencil-window generator for streaming raster images. It accepts one pixel per valid cycle in row-major order. It emits a registered ROWS x COLS window of the most recent pixels, with a valid flag that asserts only when every pixel in the window belongs to the current frame. It also emits an end-of-frame marker. It sits between the input stream and the stencil datapath (multiply/add tree), replacing the fixed 3x1, always-enabled line buffer with sizing set by parameters, frame tracking and a correct valid.

## Interface
- WIDTH, 16, pixel bit width
- IMG_W, 10, image width in pixels; IMG_W >= COLS
- IMG_H, 10, image height in rows; IMG_H >= ROWS
- ROWS, 3, window height; ROWS >= 2 (ROWS-1 line memories of depth IMG_W)
- COLS, 1, window width; COLS >= 1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  WIDTH  input pixel
- in_valid  in  1  pixel accepted this cycle (no backpressure; block always ready)
- out_data  out  ROWS*COLS*WIDTH  window; element (r,c) at bits [(r*COLS+c)*WIDTH +: WIDTH], r=0 oldest row, c=0 oldest column
- out_valid  out  1  out_data holds a complete in-frame window
- out_last  out  1  window whose bottom-right pixel is (IMG_H-1, IMG_W-1)

## Operation
- State:
  - col_cnt, 0..IMG_W-1, $clog2(IMG_W) bits.
  - row_cnt, 0..IMG_H-1, $clog2(IMG_H) bits.
  - line memories lm[0..ROWS-2], each IMG_W x WIDTH, asynchronous read, synchronous write. lm[0] holds the previous row; lm[k] holds the row k+1 back.
  - window registers w[r][c].
- On accept (in_valid=1, rst=0) at x=col_cnt:
  - Column vector: v[ROWS-1]=in_data; v[ROWS-2-k]=lm[k][x] for k=0..ROWS-2.
  - Memory writes: lm[0][x]<=in_data; lm[k][x]<=lm[k-1][x] for k>=1. These are read-before-write in the same cycle.
  - Window shift: w[r][c]<=w[r][c+1] for c<COLS-1; w[r][COLS-1]<=v[r].
  - Validity: out_valid<=(row_cnt>=ROWS-1)&&(col_cnt>=COLS-1).
  - Frame end: out_last<=that AND row_cnt==IMG_H-1 AND col_cnt==IMG_W-1.
  - col_cnt increments and wraps IMG_W-1->0. On wrap, row_cnt increments and wraps IMG_H-1->0, which starts a new frame.
- No accept: counters, memories and w hold; out_valid<=0, out_last<=0.
- Windows straddling a row boundary or using rows from the previous frame never assert out_valid. Stale memory contents are harmless. Memories are not reset.
- Valid windows per frame: (IMG_H-ROWS+1)*(IMG_W-COLS+1).
- All arithmetic is unsigned; data is passed unmodified, with no arithmetic on pixels.

## Timing
- Latency: a pixel accepted in cycle t appears in out_data in cycle t+1. out_valid and out_last are aligned with it.
- out_valid and out_last are single-cycle pulses per completing accept. Back-to-back accepts can give out_valid high on consecutive cycles.
- out_data holds its value between accepts; it changes only on the cycle after an accept or on reset.
- Reset values: out_data=0, out_valid=0, out_last=0, col_cnt=0, row_cnt=0.
- rst has priority over in_valid in the same cycle. That pixel is dropped and no memory write occurs.
- Reset mid-frame abandons the frame. The next accepted pixel is treated as (0,0), and memory contents are ignored by the validity logic.
- Frame boundary: the accept of (IMG_H-1, IMG_W-1) sets out_last (when out_valid is also set) and returns both counters to 0 in the same cycle. The next frame needs ROWS-1 full rows of warm-up again, with no bubble required.

## Test plan
Default bench parameters: WIDTH=16, IMG_W=4, IMG_H=4, ROWS=3, COLS=3. Pixel value is 10*row+col.
- Continuous stream, one frame:
  - First out_valid comes the cycle after pixel 22 (11th accept), with window {0,1,2,10,11,12,20,21,22}.
  - Exactly 4 out_valid pulses occur.
  - The last pulse has out_last=1 and window {11,12,13,21,22,23,31,32,33}.
  - No window mixes col 3 with col 0.
- Random in_valid gaps (about 50%):
  - Same 4 windows in the same order.
  - out_data holds during gaps.
  - out_valid never high in a cycle not following an accept.
- Two frames back-to-back, second frame values +100:
  - No out_valid during the first 10 accepts of frame 2.
  - First frame-2 window is {100,101,102,110,111,112,120,121,122}.
- Reset asserted after 7 accepts, with in_valid=1 in the reset cycle:
  - All outputs 0 next cycle.
  - The restarted frame produces its first window only after 11 new accepts, with no pre-reset data in it.
- Second build with ROWS=2, COLS=1, IMG_W=10, IMG_H=3, pixel = 10*row+col:
  - First valid comes after accept 11, with window {0,10}.
  - 20 valid pulses per frame.
  - Last window {19,29} with out_last=1.
